// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sharing block: function codes,
// FSM state encoding and the supported-opcode check.
package alu_share_ctrl_pkg;

  localparam logic [5:0] FUNCT_ADDU = 6'b001001;
  localparam logic [5:0] FUNCT_SUBU = 6'b001010;
  localparam logic [5:0] FUNCT_SLL  = 6'b100001;
  localparam logic [5:0] FUNCT_SLLV = 6'b110101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic funct_supported(input logic [5:0] funct);
    return (funct == FUNCT_ADDU) || (funct == FUNCT_SUBU) ||
           (funct == FUNCT_SLL)  || (funct == FUNCT_SLLV);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Combinational ALU: modulo-2^32 add/subtract and logical left shifts.
// Unsupported function codes produce zero.
module alu_share_ctrl_alu
  import alu_share_ctrl_pkg::*;
(
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  output logic [31:0] result
);

  // Operation select on the function code
  always_comb begin
    result = '0;
    case (funct)
      FUNCT_ADDU: result = rs + rt;
      FUNCT_SUBU: result = rs - rt;
      FUNCT_SLL:  result = rs << shamt;
      FUNCT_SLLV: result = rs << rt[4:0];
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between the core datapath (req0) and the
// test/debug port (req1). One operation is in flight at a time:
// IDLE accepts, EXEC computes, RESP holds the tagged result until consumed.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_rs,
  input  logic [31:0]      req0_rt,
  input  logic [4:0]       req0_shamt,
  input  logic [5:0]       req0_funct,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_rs,
  input  logic [31:0]      req1_rt,
  input  logic [4:0]       req1_shamt,
  input  logic [5:0]       req1_funct,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt0,
  output logic [CNT_W-1:0] op_cnt1
);

  state_t      state;
  logic        last_grant;
  logic        grant_id;
  logic        accept;

  logic [31:0] rs_p0;
  logic [31:0] rt_p0;
  logic [4:0]  shamt_p0;
  logic [5:0]  funct_p0;
  logic        id_p0;
  logic [31:0] alu_result;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  // Round-robin grant: a tie goes to whoever did not win last time
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else if (req1_valid)          grant_id = 1'b1;
  end

  assign req0_ready = (state == ST_IDLE) && req0_valid && (grant_id == 1'b0);
  assign req1_ready = (state == ST_IDLE) && req1_valid && (grant_id == 1'b1);
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != ST_IDLE);

  // ---- stage p0: operands captured at the accept edge ----
  // Capture the winning requester's operands; later input changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      rs_p0    <= grant_id ? req1_rs    : req0_rs;
      rt_p0    <= grant_id ? req1_rt    : req0_rt;
      shamt_p0 <= grant_id ? req1_shamt : req0_shamt;
      funct_p0 <= grant_id ? req1_funct : req0_funct;
      id_p0    <= grant_id;
    end
  end

  alu_share_ctrl_alu u_alu (
    .rs     (rs_p0),
    .rt     (rt_p0),
    .shamt  (shamt_p0),
    .funct  (funct_p0),
    .result (alu_result)
  );

  // ---- stage p1: ALU result registered onto the response channel ----
  // Control FSM with registered response and saturating completion counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      op_cnt0    <= '0;
      op_cnt1    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_grant <= grant_id;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_err    <= ~funct_supported(funct_p0);
          rsp_id     <= id_p0;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_id) op_cnt1 <= sat_inc(op_cnt1);
            else        op_cnt0 <= sat_inc(op_cnt0);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl. A second instance built with CNT_W=2
// shares all inputs so counter saturation is observed on the same traffic.
module tb_alu_share_ctrl;

  localparam logic [5:0] ADDU = 6'b001001;
  localparam logic [5:0] SUBU = 6'b001010;
  localparam logic [5:0] SLL  = 6'b100001;
  localparam logic [5:0] SLLV = 6'b110101;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_rs, req0_rt, req1_rs, req1_rt;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [5:0]  req0_funct, req1_funct;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, busy;
  logic [31:0] rsp_result;
  logic [15:0] op_cnt0, op_cnt1;

  logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_err, s_busy;
  logic [31:0] s_rsp_result;
  logic [1:0]  s_op_cnt0, s_op_cnt1;

  int checks = 0;
  int failures = 0;
  int cnt0_exp = 0;
  int cnt1_exp = 0;
  logic last_g = 1'b1;
  logic g;

  always #5 clk = ~clk;

  alu_share_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs(req0_rs),
    .req0_rt(req0_rt), .req0_shamt(req0_shamt), .req0_funct(req0_funct),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs(req1_rs),
    .req1_rt(req1_rt), .req1_shamt(req1_shamt), .req1_funct(req1_funct),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .op_cnt0(op_cnt0), .op_cnt1(op_cnt1)
  );

  alu_share_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_rs(req0_rs),
    .req0_rt(req0_rt), .req0_shamt(req0_shamt), .req0_funct(req0_funct),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_rs(req1_rs),
    .req1_rt(req1_rt), .req1_shamt(req1_shamt), .req1_funct(req1_funct),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
    .rsp_result(s_rsp_result), .rsp_err(s_rsp_err), .busy(s_busy),
    .op_cnt0(s_op_cnt0), .op_cnt1(s_op_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt0"},   32'(op_cnt0),   32'(cnt0_exp));
    chk({tag, "_cnt1"},   32'(op_cnt1),   32'(cnt1_exp));
    chk({tag, "_scnt0"},  32'(s_op_cnt0), 32'(sat3(cnt0_exp)));
    chk({tag, "_scnt1"},  32'(s_op_cnt1), 32'(sat3(cnt1_exp)));
  endtask

  // Single-requester operation with rsp_ready held high; entered and left at posedge+1 in IDLE
  task automatic run_op(input string tag, input logic id, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [31:0] exp_res, input logic exp_err);
    if (id) begin
      req1_valid = 1'b1; req1_rs = rs; req1_rt = rt; req1_shamt = sh; req1_funct = fn;
    end else begin
      req0_valid = 1'b1; req0_rs = rs; req0_rt = rt; req0_shamt = sh; req0_funct = fn;
    end
    #1;
    chk({tag, "_ready0"}, 32'(req0_ready), 32'(id == 1'b0));
    chk({tag, "_ready1"}, 32'(req1_ready), 32'(id == 1'b1));
    @(posedge clk); #1;
    last_g = id;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
    chk({tag, "_exec_vld"},  32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_vld"},    32'(rsp_valid), 32'd1);
    chk({tag, "_result"}, rsp_result, exp_res);
    chk({tag, "_id"},     32'(rsp_id), 32'(id));
    chk({tag, "_err"},    32'(rsp_err), 32'(exp_err));
    @(posedge clk); #1;
    if (id) cnt1_exp++; else cnt0_exp++;
    chk({tag, "_done_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk_cnt(tag);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_rs = '0; req0_rt = '0; req0_shamt = '0; req0_funct = '0;
    req1_valid = 1'b0; req1_rs = '0; req1_rt = '0; req1_shamt = '0; req1_funct = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",    32'(rsp_valid), 32'd0);
    chk("rst_id",     32'(rsp_id), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_err",    32'(rsp_err), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk_cnt("rst");
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // 1: req0 ADDU 5+3
    run_op("t1_addu", 1'b0, 32'd5, 32'd3, 5'd0, ADDU, 32'd8, 1'b0);

    // 2: both valid, eight back-to-back ops alternate grants
    req0_valid = 1'b1; req0_rs = 32'd10; req0_rt = 32'd20; req0_shamt = 5'd0; req0_funct = ADDU;
    req1_valid = 1'b1; req1_rs = 32'd2;  req1_rt = 32'd3;  req1_shamt = 5'd0; req1_funct = SUBU;
    #1;
    for (int i = 0; i < 8; i++) begin
      g = ~last_g;
      chk("t2_ready0", 32'(req0_ready), 32'(g == 1'b0));
      chk("t2_ready1", 32'(req1_ready), 32'(g == 1'b1));
      @(posedge clk); #1;
      last_g = g;
      chk("t2_exec_ready", 32'(req0_ready | req1_ready), 32'd0);
      @(posedge clk); #1;
      chk("t2_vld",    32'(rsp_valid), 32'd1);
      chk("t2_id",     32'(rsp_id), 32'(g));
      chk("t2_result", rsp_result, g ? 32'hFFFF_FFFF : 32'd30);
      @(posedge clk); #1;
      if (g) cnt1_exp++; else cnt0_exp++;
      chk_cnt("t2");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // 3: SLL 1<<31 held under backpressure; operand changes after accept ignored
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_rs = 32'd1; req0_rt = 32'd0; req0_shamt = 5'd31; req0_funct = SLL;
    #1;
    chk("t3_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    last_g = 1'b0;
    req0_rs = 32'hFFFF; req0_shamt = 5'd0;
    req1_valid = 1'b1; req1_funct = ADDU;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_vld",    32'(rsp_valid), 32'd1);
      chk("t3_result", rsp_result, 32'h8000_0000);
      chk("t3_ready",  32'({req0_ready, req1_ready}), 32'd0);
      chk("t3_busy",   32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    cnt0_exp++;
    chk("t3_done_vld", 32'(rsp_valid), 32'd0);
    chk_cnt("t3");

    // 4: SLLV by Rt[4:0], then an unsupported code
    run_op("t4_sllv", 1'b1, 32'h3, 32'hFFFF_FFE4, 5'd0, SLLV, 32'h30, 1'b0);
    run_op("t4_bad",  1'b1, 32'h1234, 32'h5678, 5'd3, 6'h3F, 32'd0, 1'b1);

    // 5: reset while in EXEC aborts the op and restores the tie priority
    req1_funct = ADDU;
    req0_valid = 1'b1; req0_rs = 32'd7; req0_rt = 32'd7; req0_funct = ADDU;
    #1;
    chk("t5_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("t5_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt0_exp = 0; cnt1_exp = 0; last_g = 1'b1;
    chk("t5_rst_vld",  32'(rsp_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk_cnt("t5_rst");
    @(posedge clk); #1;
    chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    req0_valid = 1'b1; req0_rs = 32'd100; req0_rt = 32'd1; req0_funct = SUBU;
    req1_valid = 1'b1; req1_rs = 32'd9;   req1_rt = 32'd9; req1_funct = ADDU;
    #1;
    chk("t5_tie_ready0", 32'(req0_ready), 32'd1);
    chk("t5_tie_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_tie_id",     32'(rsp_id), 32'd0);
    chk("t5_tie_result", rsp_result, 32'd99);
    @(posedge clk); #1;
    cnt0_exp++;
    chk_cnt("t5_tie");

    // 6: five more req0 ops; the CNT_W=2 instance pins at 3
    for (int i = 0; i < 5; i++)
      run_op("t6_sat", 1'b0, 32'(i), 32'd1, 5'd0, ADDU, 32'(i + 1), 1'b0);
    chk("t6_scnt0_max", 32'(s_op_cnt0), 32'd3);
    chk("t6_cnt0",      32'(op_cnt0), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
